// File: rtl/cc_frame_loader_if.sv
// Stream handshakes around the frame loader: the code-beat input and the
// captured-result output. The slave side is the loader itself.
interface cc_frame_loader_if;
    logic       in_valid;
    logic [3:0] in_code;
    logic [2:0] in_opt;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_code, in_opt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_code, in_opt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cc_frame_loader.sv
// Collects a five-beat code frame, presents it to an external combinational
// calculator, waits CALC_WAIT edges for the result to settle, then holds the
// captured result until the consumer takes it.
module cc_frame_loader #(
    parameter int CALC_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    cc_frame_loader_if.slave  bus,
    output logic [2:0]        cc_opt,
    output logic [3:0]        cc_n0,
    output logic [3:0]        cc_n1,
    output logic [3:0]        cc_n2,
    output logic [3:0]        cc_n3,
    output logic [3:0]        cc_n4,
    input  logic [9:0]        cc_out
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;

    // Wait-counter value on which the calculator result is captured.
    localparam logic [1:0] WAIT_LAST = 2'(CALC_WAIT - 1);

    state_t     state_reg;
    logic [2:0] count_reg;
    logic [1:0] wait_reg;
    logic       out_valid_reg;
    logic [9:0] out_data_reg;
    logic [2:0] cc_opt_reg;

    logic       in_ready_int;
    logic       beat_accept;
    logic [2:0] write_idx;

    // Beats are taken only while collecting a frame.
    assign in_ready_int = (state_reg == IDLE) || (state_reg == LOAD);
    assign beat_accept  = bus.in_valid & in_ready_int;
    // The first beat of a frame always lands in slot 0.
    assign write_idx    = (state_reg == IDLE) ? 3'd0 : count_reg;

    // Frame sequencing: collect beats, wait for the calculator, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 3'd0;
            wait_reg      <= 2'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 10'd0;
            cc_opt_reg    <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        cc_opt_reg <= bus.in_opt;
                        count_reg  <= 3'd1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (count_reg == 3'd4) begin
                            count_reg <= 3'd0;
                            wait_reg  <= 2'd0;
                            state_reg <= CALC;
                        end else begin
                            count_reg <= count_reg + 3'd1;
                        end
                    end
                end
                CALC: begin
                    if (wait_reg == WAIT_LAST) begin
                        out_data_reg  <= cc_out;
                        out_valid_reg <= 1'b1;
                        wait_reg      <= 2'd0;
                        state_reg     <= HOLD;
                    end else begin
                        wait_reg <= wait_reg + 2'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One register per code slot, written when an accepted beat targets it.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : gen_code
            logic [3:0] code_reg;

            // Capture the beat addressed to this slot; hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    code_reg <= 4'd0;
                end else if (beat_accept && (write_idx == 3'(gi))) begin
                    code_reg <= bus.in_code;
                end
            end
        end
    endgenerate

    assign cc_n0 = gen_code[0].code_reg;
    assign cc_n1 = gen_code[1].code_reg;
    assign cc_n2 = gen_code[2].code_reg;
    assign cc_n3 = gen_code[3].code_reg;
    assign cc_n4 = gen_code[4].code_reg;

    assign cc_opt        = cc_opt_reg;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_cc_frame_loader.sv
// Drives two loaders (CALC_WAIT = 1 and 3) with the same stimulus and checks
// every output each cycle against a frame-level reference model per instance.
module tb_cc_frame_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_code;
    logic [2:0] in_opt;
    logic       out_ready;
    logic [9:0] stub_out;
    logic       chk_en;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int CW = (gi == 0) ? 1 : 3;

            cc_frame_loader_if bus ();
            logic [2:0] cc_opt;
            logic [3:0] cc_n [5];

            assign bus.in_valid  = in_valid;
            assign bus.in_code   = in_code;
            assign bus.in_opt    = in_opt;
            assign bus.out_ready = out_ready;

            cc_frame_loader #(.CALC_WAIT(CW)) dut (
                .clk    (clk),
                .rst    (rst),
                .bus    (bus.slave),
                .cc_opt (cc_opt),
                .cc_n0  (cc_n[0]),
                .cc_n1  (cc_n[1]),
                .cc_n2  (cc_n[2]),
                .cc_n3  (cc_n[3]),
                .cc_n4  (cc_n[4]),
                .cc_out (stub_out)
            );

            // Reference model: beats gathered so far, a countdown to the
            // result, and the pending result.
            int         nbeats;
            int         calc_left;
            logic       m_calc;
            logic       m_valid;
            logic [9:0] m_data;
            logic [2:0] m_opt;
            logic [3:0] m_codes [5];

            always @(posedge clk) begin
                if (rst) begin
                    nbeats    <= 0;
                    calc_left <= 0;
                    m_calc    <= 1'b0;
                    m_valid   <= 1'b0;
                    m_data    <= 10'd0;
                    m_opt     <= 3'd0;
                    for (int k = 0; k < 5; k++) m_codes[k] <= 4'd0;
                end else if (m_calc) begin
                    if (calc_left == 1) begin
                        m_calc  <= 1'b0;
                        m_valid <= 1'b1;
                        m_data  <= stub_out;
                    end else begin
                        calc_left <= calc_left - 1;
                    end
                end else if (m_valid) begin
                    if (out_ready) m_valid <= 1'b0;
                end else if (in_valid) begin
                    if (nbeats == 0) m_opt <= in_opt;
                    m_codes[nbeats] <= in_code;
                    if (nbeats == 4) begin
                        nbeats    <= 0;
                        m_calc    <= 1'b1;
                        calc_left <= CW;
                    end else begin
                        nbeats <= nbeats + 1;
                    end
                end
            end

            // Compare every output with the model away from the active edge.
            always @(negedge clk) begin
                if (chk_en) begin
                    check_eq($sformatf("cw%0d in_ready", CW), 32'(bus.in_ready), 32'(!m_calc && !m_valid));
                    check_eq($sformatf("cw%0d out_valid", CW), 32'(bus.out_valid), 32'(m_valid));
                    check_eq($sformatf("cw%0d out_data", CW), 32'(bus.out_data), 32'(m_data));
                    check_eq($sformatf("cw%0d cc_opt", CW), 32'(cc_opt), 32'(m_opt));
                    for (int k = 0; k < 5; k++)
                        check_eq($sformatf("cw%0d cc_n%0d", CW, k), 32'(cc_n[k]), 32'(m_codes[k]));
                end
            end
        end
    endgenerate

    // Apply one cycle of stimulus, then advance past the next edge.
    task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] o,
                         input logic ordy, input logic r, input logic [9:0] s);
        in_valid  = v;
        in_code   = c;
        in_opt    = o;
        out_ready = ordy;
        rst       = r;
        stub_out  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy, input logic [9:0] s);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 3'd0, ordy, 1'b0, s);
    endtask

    logic [3:0] seq_a [5];
    logic [3:0] seq_b [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 4'd0;
        in_opt    = 3'd0;
        out_ready = 1'b0;
        stub_out  = 10'd0;
        seq_a = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5};
        seq_b = '{4'd9, 4'd0, 4'd15, 4'd7, 4'd2};
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 10'd0);

        // Back-to-back frame with a constant calculator result.
        for (int i = 0; i < 5; i++) drive(1'b1, seq_a[i], 3'b101, 1'b0, 1'b0, 10'd37);
        idle(5, 1'b0, 10'd37);
        idle(2, 1'b1, 10'd37);

        // Gapped frame; in_opt changes after the first beat and must be ignored.
        drive(1'b1, seq_b[0], 3'b011, 1'b1, 1'b0, 10'($urandom));
        drive(1'b1, seq_b[1], 3'b100, 1'b1, 1'b0, 10'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 3'b100, 1'b1, 1'b0, 10'($urandom));
        for (int i = 2; i < 5; i++) drive(1'b1, seq_b[i], 3'b100, 1'b1, 1'b0, 10'($urandom));
        for (int i = 0; i < 6; i++) drive(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 10'($urandom));

        // Backpressure with in_valid held high, then handshake and restart.
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(i + 8), 3'd2, 1'b0, 1'b0, 10'($urandom));
        for (int i = 0; i < 10; i++) drive(1'b1, 4'($urandom), 3'd6, 1'b0, 1'b0, 10'($urandom));
        drive(1'b1, 4'd12, 3'd1, 1'b1, 1'b0, 10'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b1, 4'(i + 1), 3'd1, 1'b0, 1'b0, 10'($urandom));

        // Reset mid-frame, then a full frame of sixes.
        drive(1'b1, 4'd11, 3'd7, 1'b0, 1'b1, 10'($urandom));
        for (int i = 0; i < 5; i++) drive(1'b1, 4'd6, 3'd4, 1'b0, 1'b0, 10'($urandom));
        idle(5, 1'b0, 10'd500);
        idle(2, 1'b1, 10'd500);

        // Reset while a result is held and the consumer is ready.
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(15 - i), 3'd3, 1'b0, 1'b0, 10'($urandom));
        idle(5, 1'b0, 10'd1023);
        drive(1'b1, 4'd5, 3'd5, 1'b1, 1'b1, 10'd1023);
        idle(2, 1'b1, 10'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            drive(($urandom % 4) != 0, 4'($urandom), 3'($urandom), ($urandom % 3) == 0,
                  ($urandom % 97) == 0, 10'($urandom));
        idle(8, 1'b1, 10'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_frame_loader.md
CC_FRAME_LOADER -- requirements
Module: cc_frame_loader

Interface
REQ-001 Parameter CALC_WAIT, default 1: number of clk edges between the last code beat and result capture; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  a code beat is present on in_code.
REQ-005 in_code  input  4  unsigned 4-bit code, one per beat.
REQ-006 in_opt  input  3  operation select; sampled only on the first beat of a frame.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 cc_opt  output  3  registered opt presented to the downstream calculator.
REQ-009 cc_n0..cc_n4  output  4 each  registered codes presented to the calculator; beat k drives cc_nk.
REQ-010 cc_out  input  10  combinational calculator result for the current cc_* values.
REQ-011 out_valid  output  1  out_data holds a captured result.
REQ-012 out_data  output  10  captured calculator result.
REQ-013 out_ready  input  1  consumer accepts out_data.

Function
REQ-014 FSM states: IDLE, LOAD, CALC, HOLD.
REQ-015 in_ready = 1 in IDLE and LOAD; in_ready = 0 in CALC and HOLD.
REQ-016 A beat is accepted on an edge where in_valid & in_ready.
REQ-017 IDLE, accepted beat: load cc_opt <= in_opt and cc_n0 <= in_code, set beat count to 1, go to LOAD.
REQ-018 LOAD, accepted beat: write in_code to cc_n[count] and increment count; in_opt is ignored.
REQ-019 LOAD: in_valid low holds state, count and all registers; gaps of any length between beats are legal.
REQ-020 Acceptance of beat 5 (count = 4) writes cc_n4, clears count to 0, clears the wait counter and enters CALC.
REQ-021 The beat counter is 3 bits and never exceeds 4.
REQ-022 cc_* registers hold their values from frame completion until the next frame's first beat.
REQ-023 CALC: the wait counter increments each edge.
REQ-024 CALC exit: on the edge where the wait counter equals CALC_WAIT-1, out_data <= cc_out, out_valid <= 1, state goes to HOLD.
REQ-025 Latency: out_valid is first high after edge E+CALC_WAIT, where E is the edge accepting beat 5.
REQ-026 HOLD: out_valid stays 1 and out_data is stable until an edge with out_ready = 1.
REQ-027 HOLD, on an edge with out_ready = 1: clear out_valid and go to IDLE.
REQ-028 A beat presented in the same cycle as the HOLD handshake is not accepted (in_ready = 0); the next frame starts the following cycle at the earliest.
REQ-029 out_ready is ignored outside HOLD.
REQ-030 in_valid is ignored in CALC and HOLD.
REQ-031 out_data is passed through unsigned, bit-exact from cc_out; no sign extension or arithmetic is applied.

Reset
REQ-032 rst = 1 at an edge forces IDLE, count = 0, wait counter = 0, out_valid = 0, out_data = 0, cc_opt = 0, cc_n0..cc_n4 = 0, regardless of state.
REQ-033 in_ready = 1 in the first cycle after reset is released.
REQ-034 rst asserted mid-frame or in HOLD discards the partial frame or pending result; the next accepted beat starts a new frame as beat 0.
REQ-035 rst takes priority over any simultaneous beat or handshake.

Verification
REQ-036 Back-to-back frame, CALC_WAIT = 1, stub cc_out = 37:
  - stimulus: beats 3,1,4,1,5 with in_opt = 3'b101 on beat 0.
  - response: cc_n0..4 = 3,1,4,1,5; cc_opt = 101; out_valid high one edge after beat 5; out_data = 37; in_ready = 0 until the handshake.
REQ-037 Gapped frame:
  - stimulus: beats 9,0,15,7,2 with 3 idle cycles after beat 1; in_opt = 3'b011 on beat 0 and 3'b100 on later beats.
  - response: cc_opt = 011; codes land in order.
REQ-038 CALC_WAIT = 3, stub cc_out that changes each cycle:
  - response: out_data equals the cc_out value present at edge E+3; out_valid does not rise earlier.
REQ-039 Backpressure:
  - stimulus: out_ready held 0 for 10 cycles with in_valid = 1 throughout.
  - response: out_data stable; no beats accepted; after out_ready = 1 for one edge, out_valid = 0 and the next beat is accepted in the following cycle.
REQ-040 Reset mid-frame:
  - stimulus: rst after 3 beats, then beats 6,6,6,6,6.
  - response: all outputs 0 after rst; cc_n0..4 = 6; exactly one result produced.
REQ-041 Reset in HOLD:
  - stimulus: rst pulse while out_valid = 1 and out_ready = 1.
  - response: out_valid = 0 and out_data = 0 after the edge; state is IDLE.
